// File: rtl/data_mem_resp.sv
// Responder end of the processor data-memory bus: word-addressed storage with a
// fixed access latency, a one-cycle ready pulse and an error flag.
module data_mem_resp #(
  parameter int WORD_WIDTH = 32,
  parameter int RAM_WIDTH  = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [RAM_WIDTH-1:0]  mem_wdata,
  output logic [RAM_WIDTH-1:0]  mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0]      LP_CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [WORD_WIDTH-3:0] LP_DEPTH    = (WORD_WIDTH-2)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [WORD_WIDTH-1:0] r_addr;
  logic [RAM_WIDTH-1:0]  r_wdata;
  logic                  r_op_wr;
  logic                  r_both;
  logic [RAM_WIDTH-1:0]  r_mem [DEPTH];
  logic [RAM_WIDTH-1:0]  r_rdata;
  logic                  r_ready;
  logic                  r_err;

  logic                  w_req;
  logic                  w_capture;
  logic                  w_enter_done;
  logic [WORD_WIDTH-1:0] w_addr_eff;
  logic [RAM_WIDTH-1:0]  w_wdata_eff;
  logic                  w_wr_eff;
  logic                  w_both_eff;
  logic                  w_misalign;
  logic                  w_oor;
  logic                  w_access_ok;
  logic                  w_err_nxt;
  logic                  w_mem_we;
  logic [IDX_W-1:0]      w_idx;

  assign w_req = mem_read | mem_write;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = LP_CNT_INIT;
          w_state_nxt = (LATENCY == 1) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_done = (w_state_nxt == S_DONE);

  // With LATENCY=1 DONE is entered at the capture edge itself, so the access
  // must use the live request rather than the not-yet-loaded capture registers.
  assign w_addr_eff  = (r_state == S_IDLE) ? mem_addr  : r_addr;
  assign w_wdata_eff = (r_state == S_IDLE) ? mem_wdata : r_wdata;
  assign w_wr_eff    = (r_state == S_IDLE) ? mem_write : r_op_wr;
  assign w_both_eff  = (r_state == S_IDLE) ? (mem_read & mem_write) : r_both;

  assign w_misalign  = |w_addr_eff[1:0];
  assign w_oor       = (w_addr_eff[WORD_WIDTH-1:2] >= LP_DEPTH);
  assign w_access_ok = ~w_misalign & ~w_oor;
  assign w_err_nxt   = w_both_eff | w_misalign | w_oor;
  assign w_idx       = w_addr_eff[IDX_W+1:2];

  // Gating with rst keeps a write whose commit edge coincides with reset out of storage.
  assign w_mem_we = w_enter_done & w_wr_eff & w_access_ok & ~rst;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_wdata_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_wr <= 1'b0;
      r_both  <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_op_wr <= mem_write;
        r_both  <= mem_read & mem_write;
      end
      r_ready <= w_enter_done;
      r_err   <= w_enter_done & w_err_nxt;
      if (w_enter_done && !w_wr_eff)
        r_rdata <= w_access_ok ? r_mem[w_idx] : '0;
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_a, rd_a, wr_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        ready_a, err_a;
  logic        rst_b, rd_b, wr_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic        ready_b, err_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.WORD_WIDTH(32), .RAM_WIDTH(32), .DEPTH(256), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst_a), .mem_read(rd_a), .mem_write(wr_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ready(ready_a), .mem_err(err_a));

  data_mem_resp #(.WORD_WIDTH(32), .RAM_WIDTH(32), .DEPTH(256), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst_b), .mem_read(rd_b), .mem_write(wr_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ready(ready_b), .mem_err(err_b));

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency-2 access; after acceptance the address is moved to chg and wdata scrambled.
  task automatic acc_a(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] chg,
                       input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = wdata;
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = chg; wdata_a = ~wdata;
    chk({31'd0, ready_a}, 32'd0, {tag, "_busy_rdy"});
    @(posedge clk); #1;
    chk({31'd0, ready_a}, 32'd1, {tag, "_rdy"});
    chk({31'd0, err_a}, {31'd0, exp_err}, {tag, "_err"});
    chk(rdata_a, exp_rdata, {tag, "_rdata"});
    @(posedge clk); #1;
    chk({31'd0, ready_a}, 32'd0, {tag, "_idle_rdy"});
  endtask

  task automatic acc_b(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input string tag);
    rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = wdata;
    @(posedge clk); #1;
    rd_b = 1'b0; wr_b = 1'b0;
    chk({31'd0, ready_b}, 32'd1, {tag, "_rdy"});
    chk({31'd0, err_b}, {31'd0, exp_err}, {tag, "_err"});
    chk(rdata_b, exp_rdata, {tag, "_rdata"});
    @(posedge clk); #1;
    chk({31'd0, ready_b}, 32'd0, {tag, "_idle_rdy"});
  endtask

  initial begin
    rst_a = 1'b1; rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
    rst_b = 1'b1; rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(rdata_a, 32'd0, "rst_rdata");
    chk({31'd0, ready_a}, 32'd0, "rst_rdy");
    chk({31'd0, err_a}, 32'd0, "rst_err");
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    acc_a(0, 1, 32'h0,   32'hCAFE0000, 32'h0,   32'h0,        0, "w0");
    acc_a(0, 1, 32'h10,  32'hDEADBEEF, 32'h10,  32'h0,        0, "w10");
    acc_a(1, 0, 32'h10,  32'h0,        32'h10,  32'hDEADBEEF, 0, "r10");
    acc_a(1, 0, 32'h6,   32'h0,        32'h6,   32'h0,        1, "rmis");
    acc_a(0, 1, 32'h400, 32'h55,       32'h400, 32'h0,        1, "woor");
    acc_a(1, 0, 32'h0,   32'h0,        32'h0,   32'hCAFE0000, 0, "r0");
    acc_a(1, 1, 32'h8,   32'hA5A5A5A5, 32'h8,   32'hCAFE0000, 1, "both");
    acc_a(1, 0, 32'h8,   32'h0,        32'h8,   32'hA5A5A5A5, 0, "r8");
    acc_a(0, 1, 32'h20,  32'h1111,     32'h20,  32'hA5A5A5A5, 0, "w20");
    acc_a(1, 0, 32'h20,  32'h0,        32'h20,  32'h1111,     0, "r20");

    // Write aborted by reset asserted in BUSY and held across the would-be commit edge
    wr_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h1234;
    @(posedge clk); #1;
    wr_a = 1'b0;
    rst_a = 1'b1;
    #1;
    chk(rdata_a, 32'd0, "arst_rdata");
    chk({31'd0, ready_a}, 32'd0, "arst_rdy");
    chk({31'd0, err_a}, 32'd0, "arst_err");
    @(posedge clk); #1;
    rst_a = 1'b0;
    chk({31'd0, ready_a}, 32'd0, "arst_nordy1");
    @(posedge clk); #1;
    chk({31'd0, ready_a}, 32'd0, "arst_nordy2");
    acc_a(1, 0, 32'h20, 32'h0, 32'h20, 32'h1111,     0, "r20_old");
    acc_a(1, 0, 32'h10, 32'h0, 32'h8,  32'hDEADBEEF, 0, "rchg");

    // Latency-1 instance: preload, then back-to-back reads with read held high
    acc_b(0, 1, 32'h0, 32'h11, 32'h0, 0, "bw0");
    acc_b(0, 1, 32'h4, 32'h22, 32'h0, 0, "bw4");
    rd_b = 1'b1; addr_b = 32'h0;
    @(posedge clk); #1;
    chk({31'd0, ready_b}, 32'd1, "bb_rdy1");
    chk(rdata_b, 32'h11, "bb_rdata1");
    addr_b = 32'h4;
    @(posedge clk); #1;
    chk({31'd0, ready_b}, 32'd0, "bb_gap");
    @(posedge clk); #1;
    chk({31'd0, ready_b}, 32'd1, "bb_rdy2");
    chk(rdata_b, 32'h22, "bb_rdata2");
    // Reset during the DONE cycle clears the pulse and read data at once
    rd_b = 1'b0;
    rst_b = 1'b1;
    #1;
    chk({31'd0, ready_b}, 32'd0, "brst_rdy");
    chk(rdata_b, 32'd0, "brst_rdata");
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk({31'd0, ready_b}, 32'd0, "brst_nordy");
    acc_b(1, 0, 32'h4, 32'h0, 32'h22, 0, "br4");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
